// File: rtl/axis_weight_preload_fifo.sv
// rtl/axis_weight_preload_fifo.sv - packs AXIS beats into weight words buffered in a small FWFT FIFO
module axis_weight_preload_fifo #(
    parameter int MAC_NUM                 = 256,
    parameter int AXIS_DATA_WIDTH         = 64,
    parameter int AXIS_PRELOAD_FIFO_DEPTH = 4,
    // MSB index of fifo_cnt; equals clogb2(DEPTH-1) for power-of-two depths
    parameter int bit_num                 = $clog2(AXIS_PRELOAD_FIFO_DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                         s_axis_tvalid,
    input  logic                         s_axis_tlast,
    output logic                         s_axis_tready,
    output logic [5*MAC_NUM-1:0]         fifo_rd_data,
    input  logic                         fifo_rd_en,
    output logic [bit_num:0]             fifo_cnt,
    output logic                         partial_word_err,
    output logic [12:0]                  words_pushed
);

    localparam int W     = 5 * MAC_NUM;
    localparam int DW    = AXIS_DATA_WIDTH;
    localparam int BEATS = W / DW;
    localparam int DEPTH = AXIS_PRELOAD_FIFO_DEPTH;
    localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ASM_W = (BEATS - 1) * DW;

    localparam logic [BC_W-1:0]  LAST_BEAT  = BC_W'(BEATS - 1);
    localparam logic [BC_W-1:0]  BC_ONE     = BC_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [bit_num:0] FULL_CNT   = (bit_num + 1)'(DEPTH);
    localparam logic [bit_num:0] CNT_ONE    = (bit_num + 1)'(1);
    localparam logic [12:0]      PUSHED_MAX = 13'h1fff;

    logic [BC_W-1:0]  beat_cnt;
    logic [ASM_W-1:0] asm_q;
    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [bit_num:0] cnt;
    logic             accept;
    logic             word_end;
    logic             push;
    logic             pop;
    logic [W-1:0]     push_word;

    // tready looks only at registered count and clear so the consumer's pop never reaches it
    assign s_axis_tready = (cnt != FULL_CNT) & ~clear;
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign word_end      = (beat_cnt == LAST_BEAT) | s_axis_tlast;
    assign push          = accept & word_end;
    assign pop           = fifo_rd_en & (cnt != '0) & ~clear;

    assign fifo_rd_data  = mem[rd_ptr];
    assign fifo_cnt      = cnt;

    // Word being pushed: stored beats below beat_cnt, the live beat at beat_cnt, zeros above
    always_comb begin
        push_word = '0;
        for (int k = 0; k < BEATS - 1; k++) begin
            if (k < int'(beat_cnt)) begin
                push_word[k*DW +: DW] = asm_q[k*DW +: DW];
            end
        end
        push_word[int'(beat_cnt)*DW +: DW] = s_axis_tdata;
    end

    // Packer: count beats and park all but the final beat in the assembly register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            asm_q    <= '0;
        end else if (clear) begin
            beat_cnt <= '0;
        end else if (accept) begin
            if (word_end) begin
                beat_cnt <= '0;
            end else begin
                beat_cnt                        <= beat_cnt + BC_ONE;
                asm_q[int'(beat_cnt)*DW +: DW]  <= s_axis_tdata;
            end
        end
    end

    // Storage array; reset so the head reads zero while empty after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= push_word;
        end
    end

    // Pointers wrap naturally; count tracks occupancy so full and empty are distinct
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                cnt <= cnt + CNT_ONE;
            end else if (pop && !push) begin
                cnt <= cnt - CNT_ONE;
            end
        end
    end

    // Sticky short-packet flag and saturating push counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            partial_word_err <= 1'b0;
            words_pushed     <= '0;
        end else if (clear) begin
            partial_word_err <= 1'b0;
            words_pushed     <= '0;
        end else if (push) begin
            if (beat_cnt != LAST_BEAT) begin
                partial_word_err <= 1'b1;
            end
            if (words_pushed != PUSHED_MAX) begin
                words_pushed <= words_pushed + 13'd1;
            end
        end
    end

endmodule

// File: tb/tb_axis_weight_preload_fifo.sv
// tb/tb_axis_weight_preload_fifo.sv - randomized self-checking bench for axis_weight_preload_fifo
module tb_axis_weight_preload_fifo;

    localparam int MAC_NUM = 256;
    localparam int DW      = 64;
    localparam int DEPTH   = 4;
    localparam int W       = 5 * MAC_NUM;
    localparam int BEATS   = W / DW;

    logic          clk;
    logic          rst_n;
    logic          clear;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
    logic          s_axis_tready;
    logic [W-1:0]  fifo_rd_data;
    logic          fifo_rd_en;
    logic [2:0]    fifo_cnt;
    logic          partial_word_err;
    logic [12:0]   words_pushed;

    int tests = 0;
    int fails = 0;

    // Reference model: queue of whole words plus the beats of the word in progress
    logic [W-1:0]  model_q [$];
    logic [DW-1:0] cur [$];
    logic          model_err;
    int            model_pushed;

    logic [DW-1:0] pkt [BEATS];
    logic          exp_ready;
    logic          seen_ready;

    axis_weight_preload_fifo #(
        .MAC_NUM(MAC_NUM),
        .AXIS_DATA_WIDTH(DW),
        .AXIS_PRELOAD_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clear(clear),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .fifo_rd_data(fifo_rd_data),
        .fifo_rd_en(fifo_rd_en),
        .fifo_cnt(fifo_cnt),
        .partial_word_err(partial_word_err),
        .words_pushed(words_pushed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_reset();
        model_q.delete();
        cur.delete();
        model_err    = 1'b0;
        model_pushed = 0;
    endtask

    task automatic idle();
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        fifo_rd_en    = 1'b0;
        clear         = 1'b0;
    endtask

    // One clock cycle, entered and left at the falling edge; updates the model from the stream rules
    task automatic step(input logic v, input logic [DW-1:0] d, input logic l,
                        input logic re, input logic clr, output logic acc);
        logic [W-1:0] w;
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        fifo_rd_en    = re;
        clear         = clr;
        #1;
        exp_ready  = (model_q.size() != DEPTH) && !clr;
        seen_ready = s_axis_tready;
        acc        = v && exp_ready;
        if (clr) begin
            model_reset();
        end else begin
            if (re && model_q.size() != 0) void'(model_q.pop_front());
            if (acc) begin
                cur.push_back(d);
                if (cur.size() == BEATS || l) begin
                    if (cur.size() != BEATS) model_err = 1'b1;
                    w = '0;
                    foreach (cur[i]) w[i*DW +: DW] = cur[i];
                    model_q.push_back(w);
                    cur.delete();
                    if (model_pushed < 8191) model_pushed++;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Send pkt[first..n-1], holding each beat until accepted, within a cycle budget
    task automatic send_pkt(input int first, input int n, input logic last, input logic pop_end);
        int   i;
        int   budget;
        logic acc;
        i      = first;
        budget = 0;
        while (i < n && budget < 200) begin
            step(1'b1, pkt[i], last && (i == n - 1), pop_end && (i == n - 1), 1'b0, acc);
            if (acc) i++;
            budget++;
        end
        idle();
        tests++;
        if (i != n) begin
            fails++;
            $display("FAIL send_pkt_timeout: sent up to beat %0d, required %0d", i, n);
        end
    endtask

    task automatic rand_pkt();
        for (int k = 0; k < BEATS; k++) pkt[k] = {$urandom, $urandom};
    endtask

    // Reference packing of the first n beats of pkt, zero-filled above
    function automatic logic [W-1:0] build(input int n);
        logic [W-1:0] w;
        w = '0;
        for (int k = 0; k < n; k++) w[k*DW +: DW] = pkt[k];
        return w;
    endfunction

    task automatic do_clear();
        logic acc;
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        model_reset();
        #12;
        tests++; if (s_axis_tready !== 1'b1) begin fails++; $display("FAIL reset_tready: got %b want 1", s_axis_tready); end
        tests++; if (fifo_cnt !== 3'd0) begin fails++; $display("FAIL reset_cnt: got %0d want 0", fifo_cnt); end
        tests++; if (partial_word_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", partial_word_err); end
        tests++; if (words_pushed !== 13'd0) begin fails++; $display("FAIL reset_pushed: got %0d want 0", words_pushed); end
        tests++; if (fifo_rd_data !== '0) begin fails++; $display("FAIL reset_rd_data: got nonzero want 0"); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_word();
        logic acc;
        do_clear();
        for (int k = 0; k < BEATS; k++) pkt[k] = DW'(k);
        send_pkt(0, BEATS - 1, 1'b0, 1'b0);
        tests++; if (fifo_cnt !== 3'd0) begin fails++; $display("FAIL single_cnt_before: got %0d want 0", fifo_cnt); end
        send_pkt(BEATS - 1, BEATS, 1'b1, 1'b0);
        tests++; if (fifo_cnt !== 3'd1) begin fails++; $display("FAIL single_cnt_after: got %0d want 1", fifo_cnt); end
        tests++; if (fifo_rd_data[63:0] !== 64'd0) begin fails++; $display("FAIL single_beat0: got %h want 0", fifo_rd_data[63:0]); end
        tests++; if (fifo_rd_data[1279:1216] !== 64'd19) begin fails++; $display("FAIL single_beat19: got %h want 13", fifo_rd_data[1279:1216]); end
        tests++; if (fifo_rd_data !== build(BEATS)) begin fails++; $display("FAIL single_word: head differs from packed beats"); end
        tests++; if (words_pushed !== 13'd1) begin fails++; $display("FAIL single_pushed: got %0d want 1", words_pushed); end
        tests++; if (partial_word_err !== 1'b0) begin fails++; $display("FAIL single_err: got %b want 0", partial_word_err); end
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
        idle();
        tests++; if (fifo_cnt !== 3'd0) begin fails++; $display("FAIL single_pop_cnt: got %0d want 0", fifo_cnt); end
    endtask

    task automatic test_fill_full();
        logic acc;
        do_clear();
        for (int w = 0; w < 4; w++) begin
            rand_pkt();
            send_pkt(0, BEATS, 1'b1, 1'b0);
        end
        tests++; if (fifo_cnt !== 3'd4) begin fails++; $display("FAIL full_cnt: got %0d want 4", fifo_cnt); end
        tests++; if (s_axis_tready !== 1'b0) begin fails++; $display("FAIL full_tready_drop: got %b want 0", s_axis_tready); end
        rand_pkt();
        for (int c = 0; c < 3; c++) begin
            step(1'b1, pkt[0], 1'b0, 1'b0, 1'b0, acc);
            tests++; if (seen_ready !== 1'b0) begin fails++; $display("FAIL full_held_%0d: tready %b want 0", c, seen_ready); end
        end
        step(1'b1, pkt[0], 1'b0, 1'b1, 1'b0, acc);
        tests++; if (seen_ready !== 1'b0) begin fails++; $display("FAIL full_pop_same_cycle: tready %b want 0", seen_ready); end
        tests++; if (fifo_cnt !== 3'd3) begin fails++; $display("FAIL full_after_pop_cnt: got %0d want 3", fifo_cnt); end
        tests++; if (s_axis_tready !== 1'b1) begin fails++; $display("FAIL full_reopen: tready %b want 1", s_axis_tready); end
        send_pkt(0, BEATS, 1'b1, 1'b0);
        tests++; if (fifo_cnt !== 3'd4) begin fails++; $display("FAIL full_refill_cnt: got %0d want 4", fifo_cnt); end
        tests++; if (fifo_rd_data !== model_q[0]) begin fails++; $display("FAIL full_head: head differs from second word"); end
        tests++; if (words_pushed !== 13'd5) begin fails++; $display("FAIL full_pushed: got %0d want 5", words_pushed); end
    endtask

    task automatic test_pair_pop();
        logic         acc;
        logic [W-1:0] w0, w1, w2;
        do_clear();
        rand_pkt(); send_pkt(0, BEATS, 1'b1, 1'b0); w0 = build(BEATS);
        rand_pkt(); send_pkt(0, BEATS, 1'b1, 1'b0); w1 = build(BEATS);
        rand_pkt(); send_pkt(0, BEATS, 1'b1, 1'b0); w2 = build(BEATS);
        tests++; if (fifo_cnt !== 3'd3) begin fails++; $display("FAIL pair_cnt3: got %0d want 3", fifo_cnt); end
        tests++; if (fifo_rd_data !== w0) begin fails++; $display("FAIL pair_word0: head is not word 0"); end
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
        tests++; if (fifo_cnt !== 3'd2) begin fails++; $display("FAIL pair_cnt2: got %0d want 2", fifo_cnt); end
        tests++; if (fifo_rd_data !== w1) begin fails++; $display("FAIL pair_word1: head is not word 1"); end
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
        idle();
        tests++; if (fifo_cnt !== 3'd1) begin fails++; $display("FAIL pair_cnt1: got %0d want 1", fifo_cnt); end
        tests++; if (fifo_rd_data !== w2) begin fails++; $display("FAIL pair_word2: head is not word 2"); end
    endtask

    task automatic test_simul_push_pop();
        logic         acc;
        logic [W-1:0] w1;
        do_clear();
        rand_pkt(); send_pkt(0, BEATS, 1'b1, 1'b0);
        rand_pkt(); send_pkt(0, BEATS, 1'b1, 1'b0); w1 = build(BEATS);
        rand_pkt(); send_pkt(0, BEATS, 1'b1, 1'b1);
        tests++; if (fifo_cnt !== 3'd2) begin fails++; $display("FAIL simul_cnt: got %0d want 2", fifo_cnt); end
        tests++; if (fifo_rd_data !== w1) begin fails++; $display("FAIL simul_head: head did not advance to word 1"); end
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
        idle();
        tests++; if (fifo_cnt !== 3'd0) begin fails++; $display("FAIL simul_drain: got %0d want 0", fifo_cnt); end
        rand_pkt(); send_pkt(0, BEATS, 1'b1, 1'b1);
        tests++; if (fifo_cnt !== 3'd1) begin fails++; $display("FAIL simul_empty_cnt: got %0d want 1", fifo_cnt); end
        tests++; if (fifo_rd_data !== build(BEATS)) begin fails++; $display("FAIL simul_empty_head: pushed word not at head"); end
    endtask

    task automatic test_short_packet();
        logic         acc;
        logic [W-1:0] exp;
        do_clear();
        exp = '0;
        for (int k = 0; k < 7; k++) begin
            pkt[k] = 64'hA5;
            exp[k*DW +: DW] = 64'hA5;
        end
        send_pkt(0, 7, 1'b1, 1'b0);
        tests++; if (fifo_cnt !== 3'd1) begin fails++; $display("FAIL short_cnt: got %0d want 1", fifo_cnt); end
        tests++; if (fifo_rd_data !== exp) begin fails++; $display("FAIL short_word: got %h want %h", fifo_rd_data[511:0], exp[511:0]); end
        tests++; if (partial_word_err !== 1'b1) begin fails++; $display("FAIL short_err: got %b want 1", partial_word_err); end
        rand_pkt(); send_pkt(0, BEATS, 1'b1, 1'b0);
        tests++; if (partial_word_err !== 1'b1) begin fails++; $display("FAIL short_err_sticky: got %b want 1", partial_word_err); end
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
        idle();
        tests++; if (fifo_rd_data !== build(BEATS)) begin fails++; $display("FAIL short_next_aligned: next word not started at beat 0"); end
        do_clear();
        tests++; if (partial_word_err !== 1'b0) begin fails++; $display("FAIL short_err_clear: got %b want 0", partial_word_err); end
    endtask

    task automatic test_clear_mid();
        logic acc;
        do_clear();
        rand_pkt(); send_pkt(0, BEATS, 1'b1, 1'b0);
        rand_pkt(); send_pkt(0, BEATS, 1'b1, 1'b0);
        rand_pkt(); send_pkt(0, 10, 1'b0, 1'b0);
        tests++; if (fifo_cnt !== 3'd2) begin fails++; $display("FAIL clear_pre_cnt: got %0d want 2", fifo_cnt); end
        step(1'b1, pkt[10], 1'b0, 1'b0, 1'b1, acc);
        idle();
        tests++; if (seen_ready !== 1'b0) begin fails++; $display("FAIL clear_tready_low: got %b want 0", seen_ready); end
        tests++; if (fifo_cnt !== 3'd0) begin fails++; $display("FAIL clear_cnt: got %0d want 0", fifo_cnt); end
        tests++; if (words_pushed !== 13'd0) begin fails++; $display("FAIL clear_pushed: got %0d want 0", words_pushed); end
        rand_pkt(); send_pkt(0, BEATS, 1'b1, 1'b0);
        tests++; if (fifo_cnt !== 3'd1) begin fails++; $display("FAIL clear_fresh_cnt: got %0d want 1", fifo_cnt); end
        tests++; if (fifo_rd_data !== build(BEATS)) begin fails++; $display("FAIL clear_fresh_word: word misaligned after clear"); end
        tests++; if (words_pushed !== 13'd1) begin fails++; $display("FAIL clear_fresh_pushed: got %0d want 1", words_pushed); end
    endtask

    task automatic test_reset_mid();
        do_clear();
        rand_pkt(); send_pkt(0, BEATS, 1'b1, 1'b0);
        rand_pkt(); send_pkt(0, BEATS, 1'b1, 1'b0);
        rand_pkt(); send_pkt(0, 10, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        tests++; if (fifo_cnt !== 3'd0) begin fails++; $display("FAIL rstmid_cnt: got %0d want 0", fifo_cnt); end
        tests++; if (words_pushed !== 13'd0) begin fails++; $display("FAIL rstmid_pushed: got %0d want 0", words_pushed); end
        tests++; if (fifo_rd_data !== '0) begin fails++; $display("FAIL rstmid_rd_data: got nonzero want 0"); end
        tests++; if (s_axis_tready !== 1'b1) begin fails++; $display("FAIL rstmid_tready: got %b want 1", s_axis_tready); end
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        rand_pkt(); send_pkt(0, BEATS, 1'b1, 1'b0);
        tests++; if (fifo_cnt !== 3'd1) begin fails++; $display("FAIL rstmid_fresh_cnt: got %0d want 1", fifo_cnt); end
        tests++; if (fifo_rd_data !== build(BEATS)) begin fails++; $display("FAIL rstmid_fresh_word: word misaligned after reset"); end
    endtask

    task automatic test_random_traffic();
        logic acc;
        int   bad;
        do_clear();
        bad = 0;
        for (int c = 0; c < 1500; c++) begin
            step($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0, acc);
            tests++;
            if (seen_ready !== exp_ready || fifo_cnt !== 3'(model_q.size()) ||
                partial_word_err !== model_err || words_pushed !== 13'(model_pushed) ||
                (model_q.size() != 0 && fifo_rd_data !== model_q[0])) begin
                fails++;
                if (bad < 10) $display("FAIL random_cycle_%0d: rdy %b/%b cnt %0d/%0d err %b/%b pushed %0d/%0d",
                                       c, seen_ready, exp_ready, fifo_cnt, model_q.size(),
                                       partial_word_err, model_err, words_pushed, model_pushed);
                bad++;
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_fill_full();
        test_pair_pop();
        test_simul_push_pop();
        test_short_packet();
        test_clear_mid();
        test_reset_mid();
        test_random_traffic();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
